lfsr_pad_gen: RTL
=================

// Module: lfsr_pad_gen
// PURPOSE
//  Pad-generation stage fed by LUT: consumes a tap pattern (LUT lutOut) and a
//  seed, then steps a W-bit Fibonacci LFSR to emit a stream of pad bytes.
//  These bytes are used by the encrypt/decrypt programs.
//  Issued by the control unit. It sits between the LUT and the ALU/regfile
//  writeback, so the program loop does not have to run an in-software LFSR.
// PARAMETERS
//  W       7   LFSR width in bits. Only the low W bits of tap/seed are used.
//  DATA_W  8   Datapath byte width. Must be >= W.
//  CNT_W   8   Width of the step counter. Maximum run length is 2**CNT_W-1.
// PORTS
//  clk          in   1       system clock, rising edge
//  init_n       in   1       synchronous active-low reset
//  tap_in       in   DATA_W  tap mask from LUT lutOut
//  seed_in      in   DATA_W  initial LFSR state from regfile
//  load         in   1       capture tap_in/seed_in (IDLE only)
//  start        in   1       begin a run of step_cnt pads (IDLE only)
//  step_cnt     in   CNT_W   number of pads to emit
//  hold         in   1       stall: freeze LFSR/counter this cycle
//  busy         out  1       high in RUN and DONE
//  pad_valid    out  1       pad_out holds a new pad this cycle
//  pad_out      out  DATA_W  pad byte, {(DATA_W-W) zeros, lfsr}
//  done         out  1       one-cycle pulse at end of run
//  lfsr_state   out  DATA_W  current LFSR state, zero-extended
//  zero_lock    out  1       stored seed is all-zero (LFSR stuck)
// BEHAVIOUR
//  Reset (clk edge with init_n=0):
//   - state=IDLE; taps, lfsr and remaining count = 0.
//   - All outputs are 0. Any in-progress run is abandoned; no done pulse.
//  Next-state function:
//   - nxt = {lfsr[W-2:0], ^(lfsr & taps)}
//   - tap_in/seed_in bits >= W are ignored.
//   - taps=0 shifts in zeros.
//  FSM:
//   - IDLE:
//     - load=1: taps<=tap_in[W-1:0], lfsr<=seed_in[W-1:0], zero_lock<=(seed==0).
//     - start=1 (same or later cycle): remaining<=step_cnt, go to RUN.
//       If load and start are high together, the load takes effect first.
//       The run starts from the new seed in the following cycle.
//     - start with step_cnt=0: go to DONE directly; no pad_valid.
//   - RUN, hold=0:
//     - pad_out<=lfsr, pad_valid<=1, lfsr<=nxt, remaining<=remaining-1.
//     - If remaining==1, go to DONE.
//   - RUN, hold=1:
//     - Nothing advances; pad_valid<=0; pad_out keeps its last value.
//   - DONE: done=1 for exactly one cycle, then go to IDLE.
//  Registered outputs:
//   - pad_valid is high the cycle after each accepted step.
//   - The last pad_valid coincides with the done cycle.
//   - Latency from start to first pad_valid = 2 cycles.
//  Ignored inputs:
//   - load and start while busy=1.
//   - hold in IDLE/DONE.
//  After a run, lfsr_state holds the advanced state. A later start continues
//  the sequence unless load is applied again.
//  zero_lock=1 does not block a run; the pads are all 0x00.
// TESTING
//  - tap=0x60, seed=0x01, load, start with step_cnt=8.
//    -> pad_out sequence 01,02,04,08,10,20,41,03, then done; lfsr_state=0x06.
//  - Same setup with step_cnt=127.
//    -> 127 pad_valid pulses, all pads distinct, final lfsr_state=0x01.
//  - hold asserted for 3 cycles mid-run (step_cnt=8).
//    -> 3-cycle gap in pad_valid; sequence unchanged; done 3 cycles late.
//  - start with step_cnt=0.
//    -> done pulse 2 cycles after start; pad_valid never asserted.
//  - seed=0x80 (only bit 7 set), load.
//    -> zero_lock=1; run of 4 yields 00,00,00,00.
//  - init_n=0 during pad 3 of a run of 8.
//    -> next cycle busy=0, pad_valid=0, done=0, lfsr_state=0.
//    Also: start while busy is ignored.

Source files
------------

// File: rtl/lfsr_pad_gen_if.sv
// Request/response bundle between the control unit and the LFSR pad generator.
// The control unit drives the tap/seed/command side and the generator returns pads and status.
interface lfsr_pad_gen_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] tap_in;
  logic [DATA_W-1:0] seed_in;
  logic              load;
  logic              start;
  logic [CNT_W-1:0]  step_cnt;
  logic              hold;
  logic              busy;
  logic              pad_valid;
  logic [DATA_W-1:0] pad_out;
  logic              done;
  logic [DATA_W-1:0] lfsr_state;
  logic              zero_lock;

  modport master (
    output tap_in, seed_in, load, start, step_cnt, hold,
    input  busy, pad_valid, pad_out, done, lfsr_state, zero_lock
  );

  modport slave (
    input  tap_in, seed_in, load, start, step_cnt, hold,
    output busy, pad_valid, pad_out, done, lfsr_state, zero_lock
  );
endinterface

// File: rtl/lfsr_pad_gen.sv
// Pad generator: steps a W-bit Fibonacci LFSR loaded from LUT taps and a seed,
// emitting one zero-extended pad byte per accepted step.
module lfsr_pad_gen #(
  parameter int W      = 7,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          init_n,
  lfsr_pad_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic [W-1:0]       taps_q;
  logic [W-1:0]       lfsr_q;
  logic [W-1:0]       lfsr_d;
  logic [CNT_W-1:0]   rem_q;
  logic [DATA_W-1:0]  pad_q;
  logic               pad_valid_q;
  logic               done_q;
  logic               busy_q;
  logic               zero_lock_q;

  // Tap and seed bits at or above W have no effect on the generator.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{bus.tap_in[DATA_W-1:W], bus.seed_in[DATA_W-1:W]};

  assign lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & taps_q)};

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q     <= IDLE;
      taps_q      <= '0;
      lfsr_q      <= '0;
      rem_q       <= '0;
      pad_q       <= '0;
      pad_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      zero_lock_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads pre-edge values of the registers.
      pad_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.load) begin
            taps_q      <= bus.tap_in[W-1:0];
            lfsr_q      <= bus.seed_in[W-1:0];
            zero_lock_q <= (bus.seed_in[W-1:0] == '0);
          end
          if (bus.start) begin
            rem_q   <= bus.step_cnt;
            busy_q  <= 1'b1;
            state_q <= (bus.step_cnt == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            pad_q       <= DATA_W'(lfsr_q);
            pad_valid_q <= 1'b1;
            lfsr_q      <= lfsr_d;
            rem_q       <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              // done rises alongside the final pad
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // An empty run enters DONE without a pulse; raise it here for one cycle first.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.pad_valid  = pad_valid_q;
  assign bus.pad_out    = pad_q;
  assign bus.done       = done_q;
  assign bus.lfsr_state = DATA_W'(lfsr_q);
  assign bus.zero_lock  = zero_lock_q;

endmodule
